// File: rtl/feature_context_stream_concat.sv
// Streaming feature/context joiner: gathers one feature beat and NUM_CTX context
// slices over valid/ready streams and emits the concatenation from a registered output.
module feature_context_stream_concat #(
  parameter int unsigned FEATURE_WIDTH = 128,
  parameter int unsigned CTX_WIDTH     = 128,
  parameter int unsigned NUM_CTX       = 3,
  parameter bit          FEATURE_FIRST = 1'b1,
  localparam int unsigned OUT_WIDTH    = FEATURE_WIDTH + NUM_CTX*CTX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     feat_valid,
  input  logic [FEATURE_WIDTH-1:0] feat_data,
  output logic                     feat_ready,
  input  logic                     ctx_valid,
  input  logic [CTX_WIDTH-1:0]     ctx_data,
  output logic                     ctx_ready,
  output logic                     out_valid,
  output logic [OUT_WIDTH-1:0]     out_data,
  input  logic                     out_ready,
  output logic [15:0]              pkt_count
);

  localparam int unsigned CTX_BITS = NUM_CTX*CTX_WIDTH;
  localparam int unsigned CNT_W    = $clog2(NUM_CTX+1);

  logic [FEATURE_WIDTH-1:0] r_feat;
  logic                     r_feat_held;
  logic [CTX_BITS-1:0]      r_ctx;
  logic [CNT_W-1:0]         r_ctx_cnt;
  logic                     r_out_valid;
  logic [OUT_WIDTH-1:0]     r_out_data;
  logic                     r_feat_ready;
  logic                     r_ctx_ready;
  logic [15:0]              r_pkt_count;

  logic                     w_feat_xfer;
  logic                     w_ctx_xfer;
  logic                     w_out_xfer;
  logic                     w_ctx_full;
  logic                     w_join;
  logic                     w_held_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [OUT_WIDTH-1:0]     w_joined;

  // Handshakes and the next-state of the gather bookkeeping
  always_comb begin
    w_feat_xfer = feat_valid & r_feat_ready;
    w_ctx_xfer  = ctx_valid & r_ctx_ready;
    w_out_xfer  = r_out_valid & out_ready;
    w_ctx_full  = (r_ctx_cnt == CNT_W'(NUM_CTX));
    w_join      = r_feat_held & w_ctx_full & (~r_out_valid | out_ready);

    w_held_nxt = r_feat_held;
    if (w_feat_xfer) w_held_nxt = 1'b1;
    if (w_join)      w_held_nxt = 1'b0;

    w_cnt_nxt = r_ctx_cnt;
    if (w_ctx_xfer) w_cnt_nxt = r_ctx_cnt + CNT_W'(1);
    if (w_join)     w_cnt_nxt = '0;

    w_joined = FEATURE_FIRST ? {r_feat, r_ctx} : {r_ctx, r_feat};
  end

  // Readies are registered copies of next-state so no input reaches them combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat       <= '0;
      r_feat_held  <= 1'b0;
      r_ctx        <= '0;
      r_ctx_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_feat_ready <= 1'b1;
      r_ctx_ready  <= 1'b1;
      r_pkt_count  <= '0;
    end else begin
      r_feat_held  <= w_held_nxt;
      r_ctx_cnt    <= w_cnt_nxt;
      r_feat_ready <= ~w_held_nxt;
      r_ctx_ready  <= (w_cnt_nxt < CNT_W'(NUM_CTX));

      if (w_feat_xfer) r_feat <= feat_data;

      for (int unsigned i = 0; i < NUM_CTX; i++) begin
        if (w_ctx_xfer && (r_ctx_cnt == CNT_W'(i)))
          r_ctx[i*CTX_WIDTH +: CTX_WIDTH] <= ctx_data;
      end

      if (w_join) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_joined;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (w_out_xfer) r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign feat_ready = r_feat_ready;
  assign ctx_ready  = r_ctx_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign pkt_count  = r_pkt_count;

endmodule

// File: doc/feature_context_stream_concat.md
# feature_context_stream_concat

Streaming, handshaked successor to the combinational feature/context concatenator. Accepts one feature vector and `NUM_CTX` context slices over valid/ready streams, gathers the slices into a full context word, and emits the joined vector from a registered output with valid/ready back-pressure. It sits between the hyperprior/temporal-context producers and the entropy-parameter network input in the HEM datapath.

## Interface
- `FEATURE_WIDTH`, 128, bits per feature vector
- `CTX_WIDTH`, 128, bits per context slice
- `NUM_CTX`, 3, context slices per output (≥1); total context field = `NUM_CTX*CTX_WIDTH`
- `FEATURE_FIRST`, 1, 1: out = {feature, context}; 0: out = {context, feature}
- `OUT_WIDTH`, derived = `FEATURE_WIDTH + NUM_CTX*CTX_WIDTH`, not overridable
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `feat_valid`  in  1  feature beat valid
- `feat_data`  in  FEATURE_WIDTH  feature vector
- `feat_ready`  out  1  block can accept a feature beat
- `ctx_valid`  in  1  context slice valid
- `ctx_data`  in  CTX_WIDTH  context slice
- `ctx_ready`  out  1  block can accept a context slice
- `out_valid`  out  1  joined vector valid
- `out_data`  out  OUT_WIDTH  joined vector
- `out_ready`  in  1  downstream accepts
- `pkt_count`  out  16  count of completed output transfers, wraps

## Operation
- Transfer on any stream = valid & ready at a rising edge.
- Feature holding register + `feat_held` flag; `feat_ready = !feat_held`. Accept sets `feat_held`, stores data.
- Context buffer `NUM_CTX*CTX_WIDTH` + counter `ctx_cnt` (0..NUM_CTX); `ctx_ready = (ctx_cnt < NUM_CTX)`. k-th accepted slice (0-based) written to context bits `[k*CTX_WIDTH +: CTX_WIDTH]`; `ctx_cnt` increments.
- Feature and context streams are independent; either may complete first; both may transfer in the same cycle.
- Join condition: `feat_held && ctx_cnt==NUM_CTX && (!out_valid || out_ready)`. On join: load `out_data` per `FEATURE_FIRST`, set `out_valid`, clear `feat_held`, reset `ctx_cnt` to 0.
- Output register: `out_valid` held with `out_data` stable until `out_ready`; output transfer without a same-cycle join clears `out_valid`. Transfer and join in the same cycle: `out_valid` stays 1, new data loaded.
- `pkt_count` increments on each output transfer, 16'hFFFF -> 16'h0000.
- Readies depend only on registered state (no combinational path from `out_ready` or any valid to any ready).

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `feat_ready`=1, `ctx_ready`=1, `pkt_count`=0, `ctx_cnt`=0, `feat_held`=0.
- Reset mid-gather: partial context and held feature discarded; output register cleared even if `out_valid` was 1.
- Latency: last required input accepted at edge N -> join at edge N+1 -> `out_valid`=1 after edge N+1.
- Throughput, no back-pressure, inputs always valid: one output every `NUM_CTX+1` cycles (gather `NUM_CTX` edges, join edge).
- Buffer full (`ctx_cnt==NUM_CTX`, `feat_held`) with `out_valid && !out_ready`: both readies low, nothing lost, stall until `out_ready`.
- `ctx_valid` while `ctx_ready`=0 or `feat_valid` while `feat_ready`=0: ignored, no state change.

## Test plan
- Reset, then feature 128'h0123456789ABCDEF0123456789ABCDEF and slices 128'hFEDCBA9876543210FEDCBA9876543210 ×3, `out_ready`=1 -> `out_valid` one cycle after last slice, `out_data` = {feature, slice2, slice1, slice0}, `pkt_count`=1.
- Slices 128'h1, 128'h2, 128'h3 sent before feature 128'hFF..FF (feature 5 cycles late) -> `out_data` = {128'hFF..FF, 128'h3, 128'h2, 128'h1}; `ctx_ready`=0 while waiting.
- `out_ready`=0 for 10 cycles with a second packet fully buffered -> `out_data` stable, `feat_ready`=`ctx_ready`=0; release -> both packets delivered in order, back-to-back join on transfer cycle.
- `FEATURE_FIRST`=0, feature 128'h0, slices all 128'hFF..FF -> `out_data` = {384'hFF..FF, 128'h0}.
- Assert `rst` after 2 of 3 slices -> all outputs at reset values next cycle; fresh packet afterwards produces correct data with no stale slices.
- 65537 continuous packets with `NUM_CTX`=1 -> outputs every 2 cycles, `pkt_count` wraps to 1.
